lcd_stream_packet_arbiter: RTL and testbench
============================================

# lcd_stream_packet_arbiter

Packet-atomic two-to-one arbiter for the 8-bit Avalon-ST LCD pixel/command stream. It shares one downstream LCD stream sink, normally the data format adapter feeding the LCD controller, between two upstream sources, for example the C2H frame renderer and the CPU command path. A grant holds from the first accepted beat through the beat carrying endofpacket, so packets are never interleaved. The output is registered.

## Interface
Parameters:
- DATA_W, 8, symbol/data width of all stream data ports.

Ports:
- clk  in  1  single clock for all logic.
- reset_n  in  1  asynchronous active-low reset.
- in0_valid / in1_valid  in  1  source k beat valid.
- in0_data / in1_data  in  DATA_W  source k data.
- in0_startofpacket / in1_startofpacket  in  1  source k start of packet.
- in0_endofpacket / in1_endofpacket  in  1  source k end of packet.
- in0_ready / in1_ready  out  1  source k beat accepted when valid && ready (ready latency 0).
- out_ready  in  1  sink ready (ready latency 0).
- out_valid  out  1  registered beat valid.
- out_data  out  DATA_W  registered data.
- out_startofpacket / out_endofpacket  out  1  registered packet delimiters, copied from the granted source.
- out_channel  out  1  index of the source that produced the current out beat.

## Operation
- Clock and reset: one clock `clk`; reset `reset_n` is asynchronous, active-low.
- States:
  - IDLE: no grant.
  - BUSY: grant register `gnt` selects the source.
- IDLE:
  - If any inK_valid is high, register `gnt` and go to BUSY. Arbitration uses inK_valid only; startofpacket is passed through, not checked.
  - Both valid: grant per the policy in Configuration.
  - Both inK_ready are 0 in IDLE.
- BUSY:
  - in[gnt]_ready = !out_valid || out_ready.
  - The other source's ready is 0.
  - An accepted beat loads the output register: out_data, out_startofpacket, out_endofpacket, out_channel = gnt, out_valid = 1.
- Output register:
  - If out_valid && out_ready and no new beat is accepted, out_valid goes to 0.
  - An accepted beat overwrites the register only while it is empty or draining that cycle. No data is lost or duplicated.
- Packet end:
  - Acceptance of a beat with in[gnt]_endofpacket = 1 moves the FSM to IDLE and sets `last = gnt`.
  - The output register still drains normally after the move.
- A single-beat packet (sop and eop both high) is legal: accept it, then return to IDLE.
- The arbiter has no timeout. A granted source that holds valid low mid-packet keeps the grant indefinitely.

## Timing
- Reset values:
  - out_valid, out_data, out_startofpacket, out_endofpacket, out_channel = 0.
  - in0_ready = in1_ready = 0.
  - FSM = IDLE, gnt = 0, last = 1.
- Arbitration bubble: one cycle per packet.
  - Valid seen in IDLE at cycle n.
  - Grant is registered at edge n+1, and ready is high in cycle n+1.
  - First beat is accepted at edge n+2 and appears on out_valid in cycle n+2.
- Steady state: one beat per cycle while out_ready = 1.
- First-beat latency from acceptance to out_valid: 1 cycle.
- Back-to-back packets from different sources: exactly one idle cycle on out_valid between the eop beat and the next sop beat, given out_ready = 1.
- Backpressure: out_valid && !out_ready holds all out signals stable and forces in[gnt]_ready = 0.
- Reset mid-packet: all state clears immediately. A partial packet is truncated downstream, and upstream sources must restart their packets.

## Configuration
- LCD_ARB_ROUND_ROBIN_EN defined:
  - If both sources are valid in IDLE, grant the source != last.
  - Because last resets to 1, in0 wins the first contention.
- LCD_ARB_ROUND_ROBIN_EN undefined:
  - Fixed priority: in0 always wins contention.
  - `last` is not implemented.

## Test plan
- Single source: in0 sends 4-beat packet 0x11..0x14 (sop on beat 1, eop on beat 4), out_ready = 1.
  - Required: out shows 0x11..0x14 on consecutive cycles, out_channel = 0, first out_valid 2 cycles after in0_valid rises.
- Contention with LCD_ARB_ROUND_ROBIN_EN: both sources hold continuous 2-beat packets (in0 0xA0,0xA1; in1 0xB0,0xB1).
  - Required: out order A0 A1, B0 B1, A0 A1, one idle cycle between packets, never interleaved.
- Contention without the macro, same stimulus.
  - Required: only in0 packets appear; in1_ready stays 0.
- Backpressure: out_ready toggles 1,0,0,1 during an in1 3-beat packet 0xC0..0xC2.
  - Required: out_data stable while stalled, all three beats delivered exactly once, in1_ready = 0 during the stall.
- Mid-packet gap: in0 drops valid for 5 cycles between beats 2 and 3 while in1 is valid.
  - Required: grant stays with in0, no in1 beat is inserted, in1 is granted after the in0 eop.
- Reset mid-packet: assert reset_n = 0 during beat 2 of an in0 packet.
  - Required: out_valid = 0 and both ready = 0 asynchronously; after release, a fresh in1 packet is delivered correctly.

Source files
------------

// File: rtl/lcd_stream_packet_arbiter.sv
// Packet-atomic 2:1 arbiter for the 8-bit LCD stream, registered output.
// Define LCD_ARB_ROUND_ROBIN_EN for round-robin contention, else in0 has priority.
module lcd_stream_packet_arbiter #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in0_valid,
    input  logic [DATA_W-1:0] in0_data,
    input  logic              in0_startofpacket,
    input  logic              in0_endofpacket,
    output logic              in0_ready,
    input  logic              in1_valid,
    input  logic [DATA_W-1:0] in1_data,
    input  logic              in1_startofpacket,
    input  logic              in1_endofpacket,
    output logic              in1_ready,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_startofpacket,
    output logic              out_endofpacket,
    output logic              out_channel
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]        state_q, state_d;
    logic              gnt_q, gnt_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_sop_q, out_sop_d;
    logic              out_eop_q, out_eop_d;
    logic              out_ch_q, out_ch_d;
`ifdef LCD_ARB_ROUND_ROBIN_EN
    logic              last_q, last_d;
`endif

    logic              busy;
    logic              can_load;
    logic              accept;
    logic              pick;
    logic              sel_valid;
    logic              sel_sop;
    logic              sel_eop;
    logic [DATA_W-1:0] sel_data;

    assign busy      = (state_q == S_BUSY);
    assign can_load  = !out_valid_q || out_ready;
    assign sel_valid = gnt_q ? in1_valid : in0_valid;
    assign sel_sop   = gnt_q ? in1_startofpacket : in0_startofpacket;
    assign sel_eop   = gnt_q ? in1_endofpacket : in0_endofpacket;
    assign sel_data  = gnt_q ? in1_data : in0_data;
    assign accept    = busy && sel_valid && can_load;

    assign in0_ready = busy && !gnt_q && can_load;
    assign in1_ready = busy && gnt_q && can_load;

    // Source picked when leaving IDLE; only consulted if some source is valid
`ifdef LCD_ARB_ROUND_ROBIN_EN
    assign pick = (in0_valid && in1_valid) ? !last_q : !in0_valid;
`else
    assign pick = !in0_valid;
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
`ifdef LCD_ARB_ROUND_ROBIN_EN
        last_d  = last_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (in0_valid || in1_valid) begin
                    gnt_d   = pick;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (accept && sel_eop) begin
                    state_d = S_IDLE;
`ifdef LCD_ARB_ROUND_ROBIN_EN
                    last_d  = gnt_q;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sop_d   = out_sop_q;
        out_eop_d   = out_eop_q;
        out_ch_d    = out_ch_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_sop_d   = sel_sop;
            out_eop_d   = sel_eop;
            out_ch_d    = gnt_q;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            gnt_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_ch_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            out_ch_q    <= out_ch_d;
        end
    end

`ifdef LCD_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    assign out_valid         = out_valid_q;
    assign out_data          = out_data_q;
    assign out_startofpacket = out_sop_q;
    assign out_endofpacket   = out_eop_q;
    assign out_channel       = out_ch_q;

endmodule

// File: tb/tb_lcd_stream_packet_arbiter.sv
// Directed cycle-table bench for lcd_stream_packet_arbiter.
// Contention expectations follow LCD_ARB_ROUND_ROBIN_EN when defined.
module tb_lcd_stream_packet_arbiter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       in0_valid, in0_sop, in0_eop, in0_ready;
    logic [7:0] in0_data;
    logic       in1_valid, in1_sop, in1_eop, in1_ready;
    logic [7:0] in1_data;
    logic       out_ready, out_valid, out_sop, out_eop, out_channel;
    logic [7:0] out_data;

    always #5 clk = ~clk;

    lcd_stream_packet_arbiter #(.DATA_W(8)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .in0_valid         (in0_valid),
        .in0_data          (in0_data),
        .in0_startofpacket (in0_sop),
        .in0_endofpacket   (in0_eop),
        .in0_ready         (in0_ready),
        .in1_valid         (in1_valid),
        .in1_data          (in1_data),
        .in1_startofpacket (in1_sop),
        .in1_endofpacket   (in1_eop),
        .in1_ready         (in1_ready),
        .out_ready         (out_ready),
        .out_valid         (out_valid),
        .out_data          (out_data),
        .out_startofpacket (out_sop),
        .out_endofpacket   (out_eop),
        .out_channel       (out_channel)
    );

    // a/b = {valid, sop, eop, data}; rdy = {in0_ready, in1_ready}
    // o = {out_valid, sop, eop, channel, data}
    typedef struct {
        logic        rst;
        logic [10:0] a;
        logic [10:0] b;
        logic        ordy;
        logic [1:0]  rdy;
        logic [11:0] o;
    } vec_t;

    localparam logic [10:0] NS = 11'h0;
    localparam logic [11:0] OZ = 12'h0;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t tv[$];

    function automatic logic [10:0] src(input logic v, input logic s,
                                        input logic e, input logic [7:0] d);
        return {v, s, e, d};
    endfunction

    function automatic logic [11:0] ob(input logic s, input logic e,
                                       input logic c, input logic [7:0] d);
        return {1'b1, s, e, c, d};
    endfunction

    function automatic vec_t mk(input logic rst, input logic [10:0] a,
                                input logic [10:0] b, input logic ordy,
                                input logic [1:0] rdy, input logic [11:0] o);
        vec_t t;
        t.rst = rst; t.a = a; t.b = b; t.ordy = ordy; t.rdy = rdy; t.o = o;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        reset_n = !t.rst;
        {in0_valid, in0_sop, in0_eop, in0_data} = t.a;
        {in1_valid, in1_sop, in1_eop, in1_data} = t.b;
        out_ready = t.ordy;
    endtask

    function automatic logic [13:0] snap();
        return {in0_ready, in1_ready, out_valid, out_sop, out_eop,
                out_channel, out_data};
    endfunction

    initial begin
        logic [10:0] A0, A1, B0, B1, C0, C1, C2, D0, D1, D2, E0, E1;
        logic [13:0] act, exp;
        logic [10:0] got[$];
        logic [10:0] g0, g1;
        int idx;

        A0 = src(1, 1, 0, 8'hA0); A1 = src(1, 0, 1, 8'hA1);
        B0 = src(1, 1, 0, 8'hB0); B1 = src(1, 0, 1, 8'hB1);
        C0 = src(1, 1, 0, 8'hC0); C1 = src(1, 0, 0, 8'hC1);
        C2 = src(1, 0, 1, 8'hC2);
        D0 = src(1, 1, 0, 8'hD0); D1 = src(1, 0, 0, 8'hD1);
        D2 = src(1, 0, 1, 8'hD2);
        E0 = src(1, 1, 0, 8'hE0); E1 = src(1, 0, 1, 8'hE1);

        // single in0 packet 0x11..0x14
        tv.push_back(mk(0, src(1, 1, 0, 8'h11), NS, 1, 2'b00, OZ));
        tv.push_back(mk(0, src(1, 1, 0, 8'h11), NS, 1, 2'b10, OZ));
        tv.push_back(mk(0, src(1, 0, 0, 8'h12), NS, 1, 2'b10, ob(1, 0, 0, 8'h11)));
        tv.push_back(mk(0, src(1, 0, 0, 8'h13), NS, 1, 2'b10, ob(0, 0, 0, 8'h12)));
        tv.push_back(mk(0, src(1, 0, 1, 8'h14), NS, 1, 2'b10, ob(0, 0, 0, 8'h13)));
        tv.push_back(mk(0, NS, NS, 1, 2'b00, ob(0, 1, 0, 8'h14)));
        tv.push_back(mk(0, NS, NS, 1, 2'b00, OZ));
        // synchronous-looking reset step so contention starts fresh
        tv.push_back(mk(1, NS, NS, 1, 2'b00, OZ));
        // contention, both sources always valid
        tv.push_back(mk(0, A0, B0, 1, 2'b00, OZ));
        tv.push_back(mk(0, A0, B0, 1, 2'b10, OZ));
        tv.push_back(mk(0, A1, B0, 1, 2'b10, ob(1, 0, 0, 8'hA0)));
        tv.push_back(mk(0, A0, B0, 1, 2'b00, ob(0, 1, 0, 8'hA1)));
`ifdef LCD_ARB_ROUND_ROBIN_EN
        tv.push_back(mk(0, A0, B0, 1, 2'b01, OZ));
        tv.push_back(mk(0, A0, B1, 1, 2'b01, ob(1, 0, 1, 8'hB0)));
        tv.push_back(mk(0, A0, B0, 1, 2'b00, ob(0, 1, 1, 8'hB1)));
`else
        tv.push_back(mk(0, A0, B0, 1, 2'b10, OZ));
        tv.push_back(mk(0, A1, B0, 1, 2'b10, ob(1, 0, 0, 8'hA0)));
        tv.push_back(mk(0, A0, B0, 1, 2'b00, ob(0, 1, 0, 8'hA1)));
`endif
        tv.push_back(mk(0, A0, B0, 1, 2'b10, OZ));
        tv.push_back(mk(0, A1, B0, 1, 2'b10, ob(1, 0, 0, 8'hA0)));
        tv.push_back(mk(0, NS, NS, 1, 2'b00, ob(0, 1, 0, 8'hA1)));
        tv.push_back(mk(0, NS, NS, 1, 2'b00, OZ));
        // in1 packet under backpressure 1,0,0,1
        tv.push_back(mk(0, NS, C0, 1, 2'b00, OZ));
        tv.push_back(mk(0, NS, C0, 1, 2'b01, OZ));
        tv.push_back(mk(0, NS, C1, 0, 2'b00, ob(1, 0, 1, 8'hC0)));
        tv.push_back(mk(0, NS, C1, 0, 2'b00, ob(1, 0, 1, 8'hC0)));
        tv.push_back(mk(0, NS, C1, 1, 2'b01, ob(1, 0, 1, 8'hC0)));
        tv.push_back(mk(0, NS, C2, 1, 2'b01, ob(0, 0, 1, 8'hC1)));
        tv.push_back(mk(0, NS, NS, 1, 2'b00, ob(0, 1, 1, 8'hC2)));
        tv.push_back(mk(0, NS, NS, 1, 2'b00, OZ));
        // in0 gap of 5 cycles mid-packet while in1 waits
        tv.push_back(mk(0, D0, E0, 1, 2'b00, OZ));
        tv.push_back(mk(0, D0, E0, 1, 2'b10, OZ));
        tv.push_back(mk(0, D1, E0, 1, 2'b10, ob(1, 0, 0, 8'hD0)));
        tv.push_back(mk(0, NS, E0, 1, 2'b10, ob(0, 0, 0, 8'hD1)));
        for (int k = 0; k < 4; k++)
            tv.push_back(mk(0, NS, E0, 1, 2'b10, OZ));
        tv.push_back(mk(0, D2, E0, 1, 2'b10, OZ));
        tv.push_back(mk(0, NS, E0, 1, 2'b00, ob(0, 1, 0, 8'hD2)));
        tv.push_back(mk(0, NS, E0, 1, 2'b01, OZ));
        tv.push_back(mk(0, NS, E1, 1, 2'b01, ob(1, 0, 1, 8'hE0)));
        tv.push_back(mk(0, NS, NS, 1, 2'b00, ob(0, 1, 1, 8'hE1)));
        tv.push_back(mk(0, NS, NS, 1, 2'b00, OZ));

        // reset state
        drive(mk(1, NS, NS, 1, 2'b00, OZ));
        #2;
        check("reset_state", 32'(snap()), 32'h0);
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i]);
            #1;
            act = snap();
            exp = {tv[i].rdy, tv[i].o};
            if (!exp[11]) begin
                act[10:0] = '0;
                exp[10:0] = '0;
            end
            check($sformatf("vec%0d", i), 32'(act), 32'(exp));
            @(posedge clk);
            #1;
        end

        // reset during beat 2 of an in0 packet
        drive(mk(0, src(1, 1, 0, 8'h71), NS, 1, 2'b00, OZ));
        repeat (2) @(posedge clk);
        #1;
        {in0_valid, in0_sop, in0_eop, in0_data} = src(1, 0, 0, 8'h72);
        #1;
        check("rst_pre", 32'({out_valid, out_data, in0_ready}),
              32'({1'b1, 8'h71, 1'b1}));
        #1;
        reset_n = 1'b0;
        #1;
        check("rst_async", 32'(snap()), 32'h0);
        in0_valid = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        idx = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            logic hs;
            if (idx < 2)
                {in1_valid, in1_sop, in1_eop, in1_data} =
                    src(1, idx == 0, idx == 1, 8'h81 + 8'(idx));
            else
                in1_valid = 1'b0;
            #1;
            hs = in1_valid && in1_ready;
            if (out_valid && out_ready)
                got.push_back({out_channel, out_sop, out_eop, out_data});
            @(posedge clk);
            #1;
            if (hs) idx++;
        end
        g0 = (got.size() > 0) ? got[0] : 11'h0;
        g1 = (got.size() > 1) ? got[1] : 11'h0;
        check("rst_after_cnt", 32'(got.size()), 32'd2);
        check("rst_after_b0", 32'(g0), 32'({1'b1, 1'b1, 1'b0, 8'h81}));
        check("rst_after_b1", 32'(g1), 32'({1'b1, 1'b0, 1'b1, 8'h82}));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
